data_memory_sync: RTL
=====================

// Module: data_memory_sync
// PURPOSE
//  Clocked successor to the combinational data RAM: word-organised storage with byte/half/word
//  loads and stores, little-endian lane select and load sign extension. Requests use a
//  valid/ready handshake; responses follow with a fixed 1-cycle latency. After reset, a
//  built-in init engine fills the array before any access is accepted. Sits between the
//  CPU MEM stage and the register-file writeback.
// PARAMETERS
//  ADDR_WIDTH    15   byte-address width; word index = req_addr[ADDR_WIDTH-1:2]
//  DEPTH         256  number of 32-bit words; index >= DEPTH is out of range
//  INIT_PATTERN  1    1: word i initialised to i; 0: all words initialised to 0
// PORTS
//  clk           in   1           rising-edge clock
//  reset_n       in   1           async active-low reset
//  req_valid     in   1           request present
//  req_ready     out  1           block can accept; request fires on req_valid & req_ready
//  req_write     in   1           1 = store, 0 = load
//  req_size      in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1           load zero-extends when 1, sign-extends when 0
//  req_addr      in   ADDR_WIDTH  byte address
//  req_wdata     in   32          store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid     out  1           one-cycle pulse per accepted request
//  rsp_rdata     out  32          load result, extended; 0 for stores and errors
//  rsp_error     out  1           misaligned / out-of-range / illegal size; valid with rsp_valid
//  init_done     out  1           high once the init sweep completes
// BEHAVIOUR
//  - Clock/reset: one clock, clk; reset_n is asynchronous and active-low.
//  - Reset: state=INIT, init_cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0,
//    init_done=0.
//  - FSM INIT: each cycle, write word init_cnt (value = INIT_PATTERN ? init_cnt : 0) and
//    increment. After word DEPTH-1 is written, go to RUN. INIT takes exactly DEPTH cycles
//    after reset release.
//  - FSM RUN: init_done=1, req_ready=1 every cycle; no other transitions except reset.
//  - Accept on posedge with req_valid & req_ready. rsp_valid=1 on the next cycle only.
//    rsp_valid is otherwise 0; there is no response backpressure. Throughput: 1 request/cycle.
//  - Error checks, any of which sets rsp_error=1, suppresses the write and returns rdata=0:
//    size=11; half with addr[0]=1; word with addr[1:0]!=0; word index >= DEPTH.
//  - Load: the selected lane is byte addr[1:0] or half addr[1], little-endian. Extension
//    follows req_unsigned. A word load returns the word as stored.
//  - Store: byte enables are derived from size and offset. Only the enabled bytes change;
//    other bytes are preserved. A store response has rsp_rdata=0, rsp_error=0 (when legal).
//  - Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1
//    at the same address.
//  - req_valid while req_ready=0 (INIT) is ignored, with no response; the requester holds
//    the request.
//  - Reset asserted mid-operation: an in-flight response is dropped (rsp_valid forced 0).
//    The full INIT sweep reruns, so memory contents are reinitialised.
//  - Address bits above the word index are not decoded beyond the range check.
// TESTING
//  1 Reset release, DEPTH=256: req_ready=0 for 256 cycles, then req_ready=1 and init_done=1.
//    Word load addr 0x0014 -> rdata 0x00000005, error 0.
//  2 Word store 0xDEADBEEF to 0x0040, load byte at 0x0043 signed -> 0xFFFFFFDE.
//    Load unsigned -> 0x000000DE. Load half at 0x0040 signed -> 0xFFFFBEEF.
//  3 Word 0x0040 = 0x11223344, byte store 0xAA to 0x0041 -> word load returns 0x1122AA44.
//    Then half store 0x5566 to 0x0042 -> 0x5566AA44.
//  4 Word load at 0x0042 / half at 0x0041 / size=11 / word addr 0x0400 (index 256)
//    -> rsp_error=1, rdata=0, and memory unchanged (verify by a follow-up legal load).
//  5 Back-to-back: store 0x0000CAFE @0x0010 in cycle N, load word @0x0010 in cycle N+1
//    -> rsp_valid in N+1 (store) and N+2 (load) with rdata 0x0000CAFE.
//  6 Assert reset_n=0 in the cycle after a load is accepted -> no rsp_valid.
//    After release, the earlier stored word reads back its init value (index) once
//    init_done=1.

Source files
------------

// File: rtl/data_memory_sync.sv
// ---------------------------------------------------------------------------
// data_memory_sync
//   Clocked word-organised data memory for the CPU MEM stage. Supports byte,
//   half and word loads/stores with little-endian lane selection and optional
//   sign extension on loads. Requests use a valid/ready handshake and every
//   accepted request produces exactly one response one cycle later. After
//   reset an init engine sweeps the whole array (word i = i, or all zero)
//   before req_ready is raised.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req_valid    request present
//   req_ready    block can accept (high only after the init sweep)
//   req_write    1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned load zero-extends when 1, sign-extends when 0
//   req_addr     byte address
//   req_wdata    store data, right-justified
//   rsp_valid    one-cycle pulse per accepted request
//   rsp_rdata    extended load result; 0 for stores and errors
//   rsp_error    misaligned / out-of-range / illegal size
//   init_done    high once the init sweep has completed
// ---------------------------------------------------------------------------
module data_memory_sync #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DEPTH        = 256,
    parameter int INIT_PATTERN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  init_done
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = ADDR_WIDTH - 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Storage: no reset on the array so it maps onto block RAM.
    logic [31:0] mem [DEPTH];

    logic [0:0]        state_reg, state_next;
    logic [MEM_AW-1:0] init_cnt_reg, init_cnt_next;

    // Request decode
    logic              fire;
    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        offset;
    logic              req_err;
    logic [3:0]        st_be;
    logic [31:0]       st_data;

    // Write port (shared between the init sweep and stores)
    logic              wr_en;
    logic [MEM_AW-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Response pipeline
    logic [31:0]       rd_word_reg;
    logic              rsp_valid_reg;
    logic              rsp_error_reg;
    logic              rsp_load_reg;
    logic [1:0]        rsp_size_reg;
    logic [1:0]        rsp_off_reg;
    logic              rsp_unsigned_reg;

    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_ext;

    // ------------------------------------------------------------------
    // Control FSM: INIT writes one word per cycle, then RUN forever.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (state_reg == ST_INIT) begin
            if (32'(init_cnt_reg) == 32'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end else begin
                init_cnt_next = init_cnt_reg + MEM_AW'(1);
            end
        end
    end

    assign req_ready = (state_reg == ST_RUN);
    assign init_done = (state_reg == ST_RUN);
    assign fire      = req_valid & req_ready;

    // ------------------------------------------------------------------
    // Decode and error detection
    // ------------------------------------------------------------------
    assign word_idx = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign offset   = req_addr[1:0];

    // Range check uses the full word index so high address bits never alias.
    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & offset[0])
                   | ((req_size == 2'b10) & (offset != 2'b00))
                   | (32'(word_idx) >= 32'(DEPTH));

    // Per-lane byte enable and store data. Byte data is replicated into
    // every lane and half data into both halves, so each lane only needs
    // its enable to pick the right bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign st_be[gi] = ((req_size == 2'b00) & (offset == 2'(gi)))
                             | ((req_size == 2'b01) & (offset[1] == 1'(gi / 2)))
                             |  (req_size == 2'b10);
            assign st_data[gi*8 +: 8] =
                (req_size == 2'b00) ? req_wdata[7:0] :
                (req_size == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                      req_wdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        if (state_reg == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_cnt_reg;
            wr_be   = 4'hF;
            wr_data = (INIT_PATTERN != 0) ? 32'(init_cnt_reg) : 32'd0;
        end else begin
            wr_en   = fire & req_write & ~req_err;
            wr_idx  = mem_idx;
            wr_be   = st_be;
            wr_data = st_data;
        end
    end

    // ------------------------------------------------------------------
    // Memory array: byte-enabled write, registered read.
    // Loads and stores never fire together, so read/write collision
    // behaviour is irrelevant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (fire) begin
            rd_word_reg <= mem[mem_idx];
        end
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_INIT;
            init_cnt_reg     <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_error_reg    <= 1'b0;
            rsp_load_reg     <= 1'b0;
            rsp_size_reg     <= 2'b00;
            rsp_off_reg      <= 2'b00;
            rsp_unsigned_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            rsp_valid_reg <= fire;
            if (fire) begin
                rsp_error_reg    <= req_err;
                rsp_load_reg     <= ~req_write & ~req_err;
                rsp_size_reg     <= req_size;
                rsp_off_reg      <= offset;
                rsp_unsigned_reg <= req_unsigned;
            end
        end
    end

    // Lane select and extension happen after the RAM output register.
    assign rd_byte = rd_word_reg[{rsp_off_reg, 3'b000} +: 8];
    assign rd_half = rsp_off_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        case (rsp_size_reg)
            2'b00:   rd_ext = rsp_unsigned_reg ? {24'd0, rd_byte}
                                               : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = rsp_unsigned_reg ? {16'd0, rd_half}
                                               : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = rd_word_reg;
        endcase
    end

    // Outputs are forced to zero outside the response cycle.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_error = rsp_valid_reg & rsp_error_reg;
    assign rsp_rdata = (rsp_valid_reg & rsp_load_reg) ? rd_ext : 32'd0;

endmodule
